ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
// Sequences the configuration-flip-flop chain (ccff_head -> ... -> ccff_tail) of the fabric grid tiles.
// Accepts decrypted bitstream words over a valid/ready stream and serialises them LSB-first into ccff_head.
// Gates the chain shift with ccff_shift_en and holds the IOs isolated (io_isol_n=0) until a verified load completes.
// Verifies chain integrity: a known header is shifted in first and must emerge at ccff_tail during the final HDR_W shifts.
// PARAMETERS
// CHAIN_LEN    1024     total ccff bits in the chain; must be >= HDR_W
// WORD_W       32       width of cfg_data words
// HDR_W        16       integrity header length (bits)
// HDR_PATTERN  16'hA5C3 header value, shifted LSB-first
// PORTS
// prog_clk       in   1       programming clock; also clocks the ccff chain
// pReset         in   1       synchronous, active-high reset
// start          in   1       1-cycle pulse: begin a load; ignored while busy=1
// cfg_data       in   WORD_W  bitstream word; bit 0 is shifted first
// cfg_valid      in   1       cfg_data valid
// cfg_ready      out  1       block can accept a word this cycle
// ccff_head      out  1       serial bit into the chain; sampled at the prog_clk edge when ccff_shift_en=1
// ccff_shift_en  out  1       chain clock-enable; one chain shift per cycle while high
// ccff_tail      in   1       last chain flop output; combinational view of the current tail bit
// io_isol_n      out  1       0 = IOs isolated; 1 only after a verified load
// busy           out  1       load in progress
// done           out  1       level: last load finished with no mismatch; cleared on start
// error          out  1       level: last load saw a tail mismatch; cleared on start
// BEHAVIOUR
// - Reset: state=IDLE; cfg_ready=0, ccff_head=0, ccff_shift_en=0, io_isol_n=0, busy=0, done=0, error=0; all counters=0.
// - Shift index s counts chain shifts from 0 to HDR_W+CHAIN_LEN-1. s increments only on cycles where ccff_shift_en=1.
// - State IDLE: on start, go to HDR. Also clear done/error, drive io_isol_n=0 and busy=1.
// - State HDR: ccff_shift_en=1 every cycle. ccff_head = HDR_PATTERN[s]. After the shift with s=HDR_W-1, go to DATA.
// - State DATA: a bit buffer holds the bits of the current word; bits_left is the number remaining.
//   - cfg_ready=1 iff bits_left==0. A word is accepted on cfg_valid & cfg_ready.
//   - On accept, bits_left = min(WORD_W, data bits still owed to the chain).
//   - Excess high bits of the final word (CHAIN_LEN mod WORD_W != 0) are discarded.
//   - A buffered word shifts out 1 bit/cycle, LSB first: ccff_shift_en=1 and ccff_head=buf[0].
//   - Shifting starts the cycle after accept. There is no shift on the accept cycle itself.
//   - When bits_left==0, ccff_shift_en=0 and ccff_head holds its last value. The chain stalls and loses no bits.
//   - Number of words consumed per load = ceil(CHAIN_LEN/WORD_W). No extra word is requested.
// - Tail check: on every shift cycle with s >= CHAIN_LEN, compare ccff_tail with HDR_PATTERN[s-CHAIN_LEN].
//   - Any mismatch sets a sticky mismatch flag. The load still runs to completion.
// - After the shift with s=HDR_W+CHAIN_LEN-1, go to FIN (1 cycle):
//   - busy=0.
//   - If no mismatch: done=1, io_isol_n=1.
//   - Otherwise: error=1, io_isol_n stays 0.
//   - Then go to IDLE; done/error/io_isol_n hold until the next start.
// - start while busy=1 has no effect. start in the FIN cycle is also ignored.
// - pReset mid-load: immediate return to reset values. The partially shifted chain is not flushed, and IOs remain isolated.
// - Counter width is $clog2(HDR_W+CHAIN_LEN+1). Bit counters never wrap within a load.
// - Minimum load latency (cfg_valid held high): HDR_W + CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 2 cycles from start to done.
// TESTING
// (Params CHAIN_LEN=40, WORD_W=16, HDR_W=8, HDR_PATTERN=8'hA5; bench models a 40-flop chain clocked by prog_clk & ccff_shift_en.)
// 1 Good load: start, then 3 words 16'h1234, 16'hBEEF, 16'h00C7 with cfg_valid always 1 -> exactly 48 shifts.
//   Chain holds {8'hC7,16'hBEEF,16'h1234} (bit0 at tail). done=1, error=0, io_isol_n=1, and 3 handshakes occur.
// 2 Backpressure: cfg_valid low for 5 cycles between each word -> ccff_shift_en=0 during the gaps. Final chain contents match test 1.
// 3 Broken chain: bench forces a 39-flop chain -> error=1, done=0, io_isol_n=0 after 48 shifts.
//   Also force ccff_tail stuck at 0 -> error=1.
// 4 Reset mid-load: pReset after 20 shifts -> next cycle all outputs at reset values.
//   A fresh start then completes a good load.
// 5 start ignored: pulse start at shift 10 and again in the FIN cycle -> single load, with total shift count 48.
//   Words consumed = 3.
// 6 Reload: after a good load, start again -> io_isol_n drops to 0 and done clears in the cycle after start.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words into the fabric ccff chain behind an integrity header,
// checks the header at the tail and releases IO isolation only after a clean load.
`default_nettype none

module ccff_chain_loader #(
  parameter int               CHAIN_LEN   = 1024,
  parameter int               WORD_W      = 32,
  parameter int               HDR_W       = 16,
  parameter logic [HDR_W-1:0] HDR_PATTERN = 16'hA5C3
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              io_isol_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TOTAL = HDR_W + CHAIN_LEN;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int IDX_W = (HDR_W > 1) ? $clog2(HDR_W) : 1;

  localparam logic [CNT_W-1:0] C_HDR_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] C_CHAIN    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] C_WORD     = CNT_W'(WORD_W);
  localparam logic [IDX_W-1:0] C_CHAIN_LO = IDX_W'(CHAIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    s_q, s_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    bits_q, bits_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic                head_q;
  logic                mism_q, mism_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                isol_n_q, isol_n_d;

  logic [CNT_W-1:0]    w_owed;
  logic [CNT_W-1:0]    w_take;
  logic [IDX_W-1:0]    w_hidx;
  logic [IDX_W-1:0]    w_tidx;
  logic                w_head;
  logic                w_shift;
  logic                w_ready;

  assign w_owed = C_CHAIN - acc_q;
  assign w_take = (int'(w_owed) < WORD_W) ? w_owed : C_WORD;
  assign w_hidx = s_q[IDX_W-1:0];
  // Modular subtraction on the low bits is exact because the tail index is always < HDR_W.
  assign w_tidx = s_q[IDX_W-1:0] - C_CHAIN_LO;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    acc_d    = acc_q;
    bits_d   = bits_q;
    buf_d    = buf_q;
    mism_d   = mism_q;
    done_d   = done_q;
    err_d    = err_q;
    isol_n_d = isol_n_q;
    w_head   = head_q;
    w_shift  = 1'b0;
    w_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_HDR;
          done_d   = 1'b0;
          err_d    = 1'b0;
          isol_n_d = 1'b0;
          mism_d   = 1'b0;
          s_d      = '0;
          acc_d    = '0;
          bits_d   = '0;
        end
      end

      S_HDR: begin
        w_shift = 1'b1;
        w_head  = HDR_PATTERN[w_hidx];
        s_d     = s_q + 1'b1;
        if (s_q == C_HDR_LAST) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        w_ready = (bits_q == '0);
        if (bits_q != '0) begin
          w_shift = 1'b1;
          w_head  = buf_q[0];
          buf_d   = buf_q >> 1;
          bits_d  = bits_q - 1'b1;
          s_d     = s_q + 1'b1;
          if ((s_q >= C_CHAIN) && (ccff_tail != HDR_PATTERN[w_tidx])) begin
            mism_d = 1'b1;
          end
          if (s_q == C_LAST) begin
            state_d = S_FIN;
          end
        end else if (cfg_valid) begin
          buf_d  = cfg_data;
          bits_d = w_take;
          acc_d  = acc_q + w_take;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        if (mism_q) begin
          err_d = 1'b1;
        end else begin
          done_d   = 1'b1;
          isol_n_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q  <= S_IDLE;
      s_q      <= '0;
      acc_q    <= '0;
      bits_q   <= '0;
      buf_q    <= '0;
      head_q   <= 1'b0;
      mism_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      isol_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      acc_q    <= acc_d;
      bits_q   <= bits_d;
      buf_q    <= buf_d;
      head_q   <= w_head;
      mism_q   <= mism_d;
      done_q   <= done_d;
      err_q    <= err_d;
      isol_n_q <= isol_n_d;
    end
  end

  assign cfg_ready     = w_ready;
  assign ccff_head     = w_head;
  assign ccff_shift_en = w_shift;
  assign io_isol_n     = isol_n_q;
  assign busy          = (state_q == S_HDR) || (state_q == S_DATA);
  assign done          = done_q;
  assign error         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a behavioural 40-flop chain (plus 39-flop and stuck-0 faults).
`default_nettype none

module tb_ccff_chain_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic        io_isol_n, busy, done, error;

  logic [39:0] chain40 = '0;
  logic [38:0] chain39 = '0;
  int          tail_mode = 0;
  int          shift_tot = 0;
  int          hs_tot = 0;
  int          tests_run = 0;
  int          fails = 0;

  logic [15:0] words [3] = '{16'h1234, 16'hBEEF, 16'h00C7};
  localparam logic [39:0] EXP_CHAIN = {8'hC7, 16'hBEEF, 16'h1234};

  ccff_chain_loader #(
    .CHAIN_LEN  (40),
    .WORD_W     (16),
    .HDR_W      (8),
    .HDR_PATTERN(8'hA5)
  ) dut (
    .prog_clk     (clk),
    .pReset       (rst),
    .start        (start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .io_isol_n    (io_isol_n),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  assign ccff_tail = (tail_mode == 0) ? chain40[0] : (tail_mode == 1) ? chain39[0] : 1'b0;

  always @(posedge clk) begin
    if (ccff_shift_en) begin
      chain40   <= {ccff_head, chain40[39:1]};
      chain39   <= {ccff_head, chain39[38:1]};
      shift_tot <= shift_tot + 1;
    end
    if (cfg_valid && cfg_ready) hs_tot <= hs_tot + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Runs one load from start to done/error. gap>0 holds cfg_valid low for gap cycles
  // each time the block asks for a word; extra=1 pulses start at shift 10 and in FIN.
  task automatic run_load(input int gap, input bit extra, output int lat, output bit to,
                          output int nsh, output int nhs, output int stall_bad,
                          output logic isol_a, output logic done_a, output logic busy_a);
    int sb, hb, last_hs, gap_left, idx;
    bit p10, pfin;
    sb = shift_tot; hb = hs_tot; last_hs = hs_tot; gap_left = gap;
    to = 0; stall_bad = 0; p10 = 0; pfin = 0;
    @(negedge clk); start = 1'b1; cfg_valid = 1'b0;
    @(negedge clk); start = 1'b0; lat = 1;
    isol_a = io_isol_n; done_a = done; busy_a = busy;
    while (!(done || error)) begin
      if (lat > 400) begin to = 1; break; end
      start = 1'b0;
      if (hs_tot != last_hs) begin last_hs = hs_tot; gap_left = gap; end
      idx = hs_tot - hb;
      if (cfg_ready && gap_left > 0) begin
        cfg_valid = 1'b0;
        gap_left--;
        if (ccff_shift_en) stall_bad++;
      end else if (idx < 3) begin
        cfg_valid = 1'b1;
        cfg_data  = words[idx];
      end else begin
        cfg_valid = 1'b0;
      end
      if (extra && !p10 && (shift_tot - sb) == 10) begin start = 1'b1; p10 = 1; end
      if (extra && !pfin && !busy && !done && !error) begin start = 1'b1; pfin = 1; end
      @(negedge clk); lat++;
    end
    start = 1'b0; cfg_valid = 1'b0;
    nsh = shift_tot - sb; nhs = hs_tot - hb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (cfg_ready !== 1'b0)     begin fails++; $display("FAIL reset_cfg_ready got %b exp 0", cfg_ready); end
    tests_run++; if (ccff_head !== 1'b0)     begin fails++; $display("FAIL reset_head got %b exp 0", ccff_head); end
    tests_run++; if (ccff_shift_en !== 1'b0) begin fails++; $display("FAIL reset_shift_en got %b exp 0", ccff_shift_en); end
    tests_run++; if (io_isol_n !== 1'b0)     begin fails++; $display("FAIL reset_isol_n got %b exp 0", io_isol_n); end
    tests_run++; if ({busy, done, error} !== 3'b000) begin fails++; $display("FAIL reset_busy_done_err got %b exp 000", {busy, done, error}); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if ({busy, ccff_shift_en} !== 2'b00) begin fails++; $display("FAIL idle_after_reset got %b exp 00", {busy, ccff_shift_en}); end
  endtask

  task automatic test_good_load();
    int lat, nsh, nhs, sbad; bit to; logic ia, da, ba;
    run_load(0, 0, lat, to, nsh, nhs, sbad, ia, da, ba);
    tests_run++; if (to !== 1'b0)        begin fails++; $display("FAIL good_timeout got %b exp 0", to); end
    tests_run++; if (nsh != 48)          begin fails++; $display("FAIL good_shifts got %0d exp 48", nsh); end
    tests_run++; if (nhs != 3)           begin fails++; $display("FAIL good_handshakes got %0d exp 3", nhs); end
    tests_run++; if (chain40 !== EXP_CHAIN) begin fails++; $display("FAIL good_chain got %h exp %h", chain40, EXP_CHAIN); end
    tests_run++; if ({done, error, io_isol_n, busy} !== 4'b1010) begin fails++; $display("FAIL good_flags done/err/isol_n/busy got %b exp 1010", {done, error, io_isol_n, busy}); end
    tests_run++; if (lat != 53)          begin fails++; $display("FAIL good_latency got %0d exp 53", lat); end
  endtask

  task automatic test_backpressure();
    int lat, nsh, nhs, sbad; bit to; logic ia, da, ba;
    chain40 = '0;
    run_load(5, 0, lat, to, nsh, nhs, sbad, ia, da, ba);
    tests_run++; if (to !== 1'b0)  begin fails++; $display("FAIL bp_timeout got %b exp 0", to); end
    tests_run++; if (sbad != 0)    begin fails++; $display("FAIL bp_shift_in_gap got %0d exp 0", sbad); end
    tests_run++; if (nsh != 48)    begin fails++; $display("FAIL bp_shifts got %0d exp 48", nsh); end
    tests_run++; if (chain40 !== EXP_CHAIN) begin fails++; $display("FAIL bp_chain got %h exp %h", chain40, EXP_CHAIN); end
    tests_run++; if ({done, error, io_isol_n} !== 3'b101) begin fails++; $display("FAIL bp_flags got %b exp 101", {done, error, io_isol_n}); end
    tests_run++; if (lat != 68)    begin fails++; $display("FAIL bp_latency got %0d exp 68", lat); end
  endtask

  task automatic test_broken_chain();
    int lat, nsh, nhs, sbad; bit to; logic ia, da, ba;
    tail_mode = 1;
    run_load(0, 0, lat, to, nsh, nhs, sbad, ia, da, ba);
    tests_run++; if (nsh != 48) begin fails++; $display("FAIL short_chain_shifts got %0d exp 48", nsh); end
    tests_run++; if ({done, error, io_isol_n} !== 3'b010) begin fails++; $display("FAIL short_chain_flags got %b exp 010", {done, error, io_isol_n}); end
    tail_mode = 2;
    run_load(0, 0, lat, to, nsh, nhs, sbad, ia, da, ba);
    tests_run++; if ({done, error, io_isol_n} !== 3'b010) begin fails++; $display("FAIL stuck0_flags got %b exp 010", {done, error, io_isol_n}); end
    tail_mode = 0;
  endtask

  task automatic test_reset_midload();
    int sb, lat, nsh, nhs, sbad; bit to; logic ia, da, ba;
    sb = shift_tot;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cfg_valid = 1'b1; cfg_data = words[0];
    for (int i = 0; i < 100; i++) begin
      if (shift_tot - sb == 20) break;
      @(negedge clk);
    end
    tests_run++; if (shift_tot - sb != 20) begin fails++; $display("FAIL midload_reach20 got %0d exp 20", shift_tot - sb); end
    rst = 1'b1; cfg_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    tests_run++; if ({cfg_ready, ccff_head, ccff_shift_en, io_isol_n, busy, done, error} !== 7'b0)
      begin fails++; $display("FAIL midload_reset_outputs got %b exp 0000000", {cfg_ready, ccff_head, ccff_shift_en, io_isol_n, busy, done, error}); end
    run_load(0, 0, lat, to, nsh, nhs, sbad, ia, da, ba);
    tests_run++; if ({done, error, io_isol_n} !== 3'b101 || chain40 !== EXP_CHAIN || nsh != 48)
      begin fails++; $display("FAIL midload_reload got flags %b chain %h shifts %0d exp 101 %h 48", {done, error, io_isol_n}, chain40, EXP_CHAIN, nsh); end
  endtask

  task automatic test_start_ignored();
    int lat, nsh, nhs, sbad, sb; bit to; logic ia, da, ba;
    sb = shift_tot;
    run_load(0, 1, lat, to, nsh, nhs, sbad, ia, da, ba);
    tests_run++; if (nsh != 48) begin fails++; $display("FAIL ign_shifts got %0d exp 48", nsh); end
    tests_run++; if (nhs != 3)  begin fails++; $display("FAIL ign_words got %0d exp 3", nhs); end
    repeat (3) @(negedge clk);
    tests_run++; if ({busy, done} !== 2'b01) begin fails++; $display("FAIL ign_after_fin busy/done got %b exp 01", {busy, done}); end
    tests_run++; if (shift_tot - sb != 48)   begin fails++; $display("FAIL ign_total_shifts got %0d exp 48", shift_tot - sb); end
  endtask

  task automatic test_reload();
    int lat, nsh, nhs, sbad; bit to; logic ia, da, ba;
    run_load(0, 0, lat, to, nsh, nhs, sbad, ia, da, ba);
    tests_run++; if ({ia, da, ba} !== 3'b001) begin fails++; $display("FAIL reload_after_start isol_n/done/busy got %b exp 001", {ia, da, ba}); end
    tests_run++; if ({done, io_isol_n} !== 2'b11) begin fails++; $display("FAIL reload_final got %b exp 11", {done, io_isol_n}); end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_backpressure();
    test_broken_chain();
    test_reset_midload();
    test_start_ignored();
    test_reload();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire
